// File: rtl/sram_port_arbiter_if.sv
// Request, response and SRAM-port bundle shared between requesters, the
// port arbiter and the dual-port block SRAM.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            wr_valid;
  logic [NUM_REQ-1:0]            wr_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [NUM_REQ-1:0]            rd_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          sram_ena;
  logic                          sram_wea;
  logic [ADDR_WIDTH-1:0]         sram_addra;
  logic [DATA_WIDTH-1:0]         sram_dina;
  logic                          sram_enb;
  logic [ADDR_WIDTH-1:0]         sram_addrb;
  logic [DATA_WIDTH-1:0]         sram_doutb;

  // Requester/SRAM side of the bundle.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, sram_doutb,
    input  wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data,
    input  sram_ena, sram_wea, sram_addra, sram_dina, sram_enb, sram_addrb
  );

  // Arbiter side of the bundle.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, sram_doutb,
    output wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data,
    output sram_ena, sram_wea, sram_addra, sram_dina, sram_enb, sram_addrb
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin write/read arbiter in front of a simple dual-port SRAM with
// registered port signals, tagged read responses and same-address stall.
module sram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 2
) (
  input  logic                clka,
  input  logic                reset,
  sram_port_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] vld,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            p;
    logic [IDX_W:0]   s;
    logic [IDX_W-1:0] c;
    p = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (IDX_W+1)'(k);
      if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
      c = s[IDX_W-1:0];
      if (!p.found && vld[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_a [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wr_addr_a[g] = bus.wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_a[g] = bus.wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr_a[g] = bus.rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
  pick_t              wr_pick, rd_pick;
  logic               collide;
  logic               wr_acc_p0, rd_acc_p0;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;

  // Stage p0: combinational grant selection and collision stall
  always_comb begin
    wr_pick   = rr_pick(bus.wr_valid, wr_ptr_q);
    rd_pick   = rr_pick(bus.rd_valid, rd_ptr_q);
    // A read hitting the address being written this cycle must wait one
    // cycle so it is issued after the write has committed.
    collide   = wr_pick.found && rd_pick.found &&
                (wr_addr_a[wr_pick.idx] == rd_addr_a[rd_pick.idx]);
    wr_acc_p0 = wr_pick.found && !reset;
    rd_acc_p0 = rd_pick.found && !collide && !reset;
    wr_gnt    = wr_acc_p0 ? (NUM_REQ'(1) << wr_pick.idx) : '0;
    rd_gnt    = rd_acc_p0 ? (NUM_REQ'(1) << rd_pick.idx) : '0;
    wr_ptr_d  = wr_acc_p0 ? ptr_next(wr_pick.idx) : wr_ptr_q;
    rd_ptr_d  = rd_acc_p0 ? ptr_next(rd_pick.idx) : rd_ptr_q;
  end

  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;

  always_ff @(posedge clka) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  logic                  sram_ena_p1_q;
  logic [ADDR_WIDTH-1:0] sram_addra_p1_q;
  logic [DATA_WIDTH-1:0] sram_dina_p1_q;
  logic                  sram_enb_p1_q;
  logic [ADDR_WIDTH-1:0] sram_addrb_p1_q;
  logic [ID_WIDTH-1:0]   rd_id_p1_q;

  // Stage p1: registered SRAM port signals
  always_ff @(posedge clka) begin
    if (reset) begin
      sram_ena_p1_q   <= 1'b0;
      sram_addra_p1_q <= '0;
      sram_dina_p1_q  <= '0;
      sram_enb_p1_q   <= 1'b0;
      sram_addrb_p1_q <= '0;
      rd_id_p1_q      <= '0;
    end else begin
      sram_ena_p1_q <= wr_acc_p0;
      sram_enb_p1_q <= rd_acc_p0;
      if (wr_acc_p0) begin
        sram_addra_p1_q <= wr_addr_a[wr_pick.idx];
        sram_dina_p1_q  <= wr_data_a[wr_pick.idx];
      end
      if (rd_acc_p0) begin
        sram_addrb_p1_q <= rd_addr_a[rd_pick.idx];
        rd_id_p1_q      <= ID_WIDTH'(rd_pick.idx);
      end
    end
  end

  assign bus.sram_ena   = sram_ena_p1_q;
  assign bus.sram_wea   = sram_ena_p1_q;
  assign bus.sram_addra = sram_addra_p1_q;
  assign bus.sram_dina  = sram_dina_p1_q;
  assign bus.sram_enb   = sram_enb_p1_q;
  assign bus.sram_addrb = sram_addrb_p1_q;

  logic                rsp_vld_p2_q;
  logic [ID_WIDTH-1:0] rsp_id_p2_q;

  // Stage p2: response tag aligned with the SRAM's registered read data
  always_ff @(posedge clka) begin
    if (reset) begin
      rsp_vld_p2_q <= 1'b0;
      rsp_id_p2_q  <= '0;
    end else begin
      rsp_vld_p2_q <= sram_enb_p1_q;
      if (sram_enb_p1_q) rsp_id_p2_q <= rd_id_p1_q;
    end
  end

  assign bus.rsp_valid = rsp_vld_p2_q;
  assign bus.rsp_id    = rsp_id_p2_q;
  assign bus.rsp_data  = bus.sram_doutb;

endmodule
